// File: rtl/fir_pkg.sv
// Shared definitions for the FIR packet scheduler.
// Holds the scheduler FSM state type, the default parameter values and the
// helpers that derive the packet width and the channel-index width.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } firState_e;

  localparam int DEF_SAMPLES_NUM      = 8;
  localparam int DEF_IN_SAMPLE_WIDTH  = 16;
  localparam int DEF_OUT_SAMPLE_WIDTH = 32;
  localparam int DEF_CHANNELS         = 1;
  localparam int DEF_LATENCY_PACKETS  = 2;

  function automatic int packetBits(input int samples, input int sampleWidth);
    return samples * sampleWidth;
  endfunction

  // A single channel still gets a 1-bit index so the port never vanishes.
  function automatic int chanWidth(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fir_result_delay.sv
// Result delay line between the filter and the SPI transmit register.
// Stage 0 takes filter results; every received packet shifts the line one
// place toward txDataOut and clears stage 0. A result written in the same
// cycle as a shift lands directly in the shifted position.
// Ports:
//   clkIn, resetIn  clock and asynchronous active-high reset
//   shiftIn         packet received: advance the line
//   writeIn         accepted filter result present on dataIn
//   dataIn          filter result
//   txDataOut       packet the SPI slave shifts out next transaction
module fir_result_delay #(
  parameter int LATENCY_PACKETS = 2,
  parameter int PACKET_BITS     = 256
)(
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   shiftIn,
  input  logic                   writeIn,
  input  logic [PACKET_BITS-1:0] dataIn,
  output logic [PACKET_BITS-1:0] txDataOut
);

  // Stage i lives at lineQ[i*PACKET_BITS +: PACKET_BITS].
  localparam int LINE_W = (LATENCY_PACKETS - 1) * PACKET_BITS;

  logic [LINE_W-1:0]      lineQ;
  logic [PACKET_BITS-1:0] oldest;

  assign oldest = lineQ[LINE_W-1 -: PACKET_BITS];

  generate
    if (LATENCY_PACKETS == 2) begin : gShort
      // Only one stage: a same-cycle result bypasses straight to txDataOut.
      always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
          lineQ     <= '0;
          txDataOut <= '0;
        end else if (shiftIn) begin
          txDataOut <= writeIn ? dataIn : oldest;
          lineQ     <= '0;
        end else if (writeIn) begin
          lineQ <= dataIn;
        end
      end
    end else begin : gLong
      logic [LINE_W-1:0] shifted;

      always_comb begin
        shifted = {lineQ[LINE_W-PACKET_BITS-1:0], {PACKET_BITS{1'b0}}};
        if (writeIn) shifted[PACKET_BITS +: PACKET_BITS] = dataIn;
      end

      always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
          lineQ     <= '0;
          txDataOut <= '0;
        end else if (shiftIn) begin
          txDataOut <= oldest;
          lineQ     <= shifted;
        end else if (writeIn) begin
          lineQ[PACKET_BITS-1:0] <= dataIn;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fir_packet_scheduler.sv
// Schedules SPI-received packets onto a FIR filter and returns the results
// to the SPI slave a fixed number of packet transactions later.
// Ports:
//   clkIn, resetIn    clock and asynchronous active-high reset
//   rxValidIn         one-cycle pulse: packet received on rxDataIn
//   rxDataIn          received packet, first-received bit at MSB
//   abortIn           slave select raised mid-packet: restart channel count
//   firStartOut       one-cycle start pulse to the filter
//   firDataOut        unpacked samples, sample 0 in the low bits
//   firChannelOut     round-robin channel of the issued packet
//   firDoneIn         one-cycle filter completion pulse
//   firResultIn       filter result, valid with firDoneIn
//   txDataOut         packet shifted out on the next SPI transaction
//   busyOut           a packet is being issued or computed
//   overrunOut        sticky: a packet arrived while the filter was busy
module fir_packet_scheduler
  import fir_pkg::*;
#(
  parameter int  SAMPLES_NUM      = DEF_SAMPLES_NUM,
  parameter int  IN_SAMPLE_WIDTH  = DEF_IN_SAMPLE_WIDTH,
  parameter int  OUT_SAMPLE_WIDTH = DEF_OUT_SAMPLE_WIDTH,
  parameter int  CHANNELS         = DEF_CHANNELS,
  parameter int  LATENCY_PACKETS  = DEF_LATENCY_PACKETS,
  localparam int PACKET_BITS      = packetBits(SAMPLES_NUM, OUT_SAMPLE_WIDTH),
  localparam int CHAN_W           = chanWidth(CHANNELS),
  localparam int FIR_DATA_W       = SAMPLES_NUM * IN_SAMPLE_WIDTH
)(
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   rxValidIn,
  input  logic [PACKET_BITS-1:0] rxDataIn,
  input  logic                   abortIn,
  output logic                   firStartOut,
  output logic [FIR_DATA_W-1:0]  firDataOut,
  output logic [CHAN_W-1:0]      firChannelOut,
  input  logic                   firDoneIn,
  input  logic [PACKET_BITS-1:0] firResultIn,
  output logic [PACKET_BITS-1:0] txDataOut,
  output logic                   busyOut,
  output logic                   overrunOut
);

  firState_e             state, stateNext;
  logic [CHAN_W-1:0]     chanCnt;
  logic                  staleQ;
  logic [FIR_DATA_W-1:0] unpacked;
  logic                  accept;
  logic                  dropped;
  logic                  doneInWait;
  logic                  resultWrite;

  assign accept      = rxValidIn && (state == IDLE);
  assign dropped     = rxValidIn && (state != IDLE);
  assign doneInWait  = firDoneIn && (state == WAIT);
  assign resultWrite = doneInWait && !staleQ;

  // Sample k is taken from the MSB end; trailing packet bits are unused.
  always_comb begin
    unpacked = '0;
    for (int k = 0; k < SAMPLES_NUM; k++) begin
      unpacked[k*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH] =
        rxDataIn[PACKET_BITS-1-k*IN_SAMPLE_WIDTH -: IN_SAMPLE_WIDTH];
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    firStartOut = 1'b0;
    busyOut     = 1'b1;
    unique case (state)
      IDLE: begin
        busyOut = 1'b0;
        if (rxValidIn) stateNext = ISSUE;
      end
      ISSUE: begin
        firStartOut = 1'b1;
        stateNext   = WAIT;
      end
      WAIT: begin
        if (firDoneIn) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      firDataOut    <= '0;
      firChannelOut <= '0;
      chanCnt       <= '0;
      staleQ        <= 1'b0;
      overrunOut    <= 1'b0;
    end else begin
      if (accept) begin
        firDataOut    <= unpacked;
        firChannelOut <= chanCnt;
      end
      if (abortIn) chanCnt <= '0;
      else if (accept) chanCnt <= (chanCnt == CHAN_W'(CHANNELS - 1)) ? '0 : chanCnt + 1'b1;
      // A done pulse in WAIT always retires the in-flight job, so it also
      // consumes the stale mark; a drop in the same cycle does not re-arm it.
      if (doneInWait) staleQ <= 1'b0;
      else if (dropped) staleQ <= 1'b1;
      if (dropped) overrunOut <= 1'b1;
    end
  end

  fir_result_delay #(
    .LATENCY_PACKETS(LATENCY_PACKETS),
    .PACKET_BITS    (PACKET_BITS)
  ) resultDelay (
    .clkIn    (clkIn),
    .resetIn  (resetIn),
    .shiftIn  (rxValidIn),
    .writeIn  (resultWrite),
    .dataIn   (firResultIn),
    .txDataOut(txDataOut)
  );

endmodule

// File: tb/tb_fir_packet_scheduler.sv
// Bench for fir_packet_scheduler: two instances (latency 2 and 4) share one
// stimulus stream; a packet-level model predicts every output each cycle.
module tb_fir_packet_scheduler;

  localparam logic [63:0] R1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] R2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] R3 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] R4 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] R5 = 64'h0BAD_C0DE_8765_4321;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetIn = 1'b1, rxValidIn = 1'b0, abortIn = 1'b0, firDoneIn = 1'b0;
  logic [63:0] rxDataIn = '0, firResultIn = '0;

  logic        startA, startB, busyA, busyB, ovrA, ovrB;
  logic [31:0] dataA, dataB;
  logic [0:0]  chA, chB;
  logic [63:0] txA, txB;

  int nVectors = 0, nMis = 0;
  bit compareEn = 1'b0;

  fir_packet_scheduler #(.SAMPLES_NUM(2), .IN_SAMPLE_WIDTH(16), .OUT_SAMPLE_WIDTH(32),
                         .CHANNELS(2), .LATENCY_PACKETS(2)) dutA (
    .clkIn(clk), .resetIn(resetIn), .rxValidIn(rxValidIn), .rxDataIn(rxDataIn),
    .abortIn(abortIn), .firStartOut(startA), .firDataOut(dataA), .firChannelOut(chA),
    .firDoneIn(firDoneIn), .firResultIn(firResultIn), .txDataOut(txA),
    .busyOut(busyA), .overrunOut(ovrA));

  fir_packet_scheduler #(.SAMPLES_NUM(2), .IN_SAMPLE_WIDTH(16), .OUT_SAMPLE_WIDTH(32),
                         .CHANNELS(2), .LATENCY_PACKETS(4)) dutB (
    .clkIn(clk), .resetIn(resetIn), .rxValidIn(rxValidIn), .rxDataIn(rxDataIn),
    .abortIn(abortIn), .firStartOut(startB), .firDataOut(dataB), .firChannelOut(chB),
    .firDoneIn(firDoneIn), .firResultIn(firResultIn), .txDataOut(txB),
    .busyOut(busyB), .overrunOut(ovrB));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] unpack(input logic [63:0] pkt);
    logic [31:0] r = '0;
    logic [63:0] s;
    for (int k = 0; k < 2; k++) begin
      s = pkt >> (64 - 16 * (k + 1));
      r = r | ({16'h0, s[15:0]} << (16 * k));
    end
    return r;
  endfunction

  // Packet-level model: a result retired while n packets have been received
  // is scheduled to be transmitted on receipt of packet n + LATENCY - 1.
  int          cyc = 0, nPulses = 0, mAcceptCyc = 0, mChan = 0, mChanOut = 0;
  bit          mOcc = 0, mStale = 0, mOverrun = 0, mStart = 0;
  bit          inWait, endsJob, accept;
  logic [31:0] mFirData = '0;
  logic [63:0] mTxA = '0, mTxB = '0;
  logic [63:0] schedA [int];
  logic [63:0] schedB [int];

  initial forever begin
    @(posedge clk);
    cyc++;
    if (resetIn) begin
      nPulses = 0; mOcc = 0; mStale = 0; mOverrun = 0; mStart = 0;
      mChan = 0; mChanOut = 0; mFirData = '0; mTxA = '0; mTxB = '0;
      schedA.delete(); schedB.delete();
    end else begin
      inWait  = mOcc && (cyc >= mAcceptCyc + 2);
      endsJob = inWait && firDoneIn;
      accept  = rxValidIn && !mOcc;
      if (endsJob && !mStale) begin
        schedA[nPulses + 1] = firResultIn;
        schedB[nPulses + 3] = firResultIn;
      end
      if (rxValidIn) begin
        nPulses++;
        mTxA = schedA.exists(nPulses) ? schedA[nPulses] : 64'h0;
        mTxB = schedB.exists(nPulses) ? schedB[nPulses] : 64'h0;
        if (mOcc) mOverrun = 1;
      end
      if (endsJob) mStale = 0;
      else if (rxValidIn && mOcc) mStale = 1;
      if (endsJob) mOcc = 0;
      mStart = accept;
      if (accept) begin
        mOcc = 1; mAcceptCyc = cyc; mChanOut = mChan; mFirData = unpack(rxDataIn);
      end
      if (abortIn) mChan = 0;
      else if (accept) mChan = (mChan + 1) % 2;
    end
  end

  initial forever begin
    @(negedge clk);
    if (compareEn) begin
      check("startA", 64'(startA), 64'(mStart));
      check("startB", 64'(startB), 64'(mStart));
      check("busyA", 64'(busyA), 64'(mOcc));
      check("busyB", 64'(busyB), 64'(mOcc));
      check("overrunA", 64'(ovrA), 64'(mOverrun));
      check("overrunB", 64'(ovrB), 64'(mOverrun));
      check("chanA", 64'(chA), 64'(mChanOut));
      check("chanB", 64'(chB), 64'(mChanOut));
      check("firDataA", 64'(dataA), 64'(mFirData));
      check("firDataB", 64'(dataB), 64'(mFirData));
      check("txA", txA, mTxA);
      check("txB", txB, mTxB);
    end
  end

  task automatic pulse(input logic [63:0] d);
    rxValidIn = 1'b1; rxDataIn = d;
    tick();
    rxValidIn = 1'b0;
  endtask

  task automatic done(input logic [63:0] r);
    firDoneIn = 1'b1; firResultIn = r;
    tick();
    firDoneIn = 1'b0;
  endtask

  int cd = 0;

  initial begin
    tick();
    tick();
    resetIn = 1'b0;
    compareEn = 1'b1;
    check("rst_start", 64'(startA), 64'h0);
    check("rst_busy", 64'(busyA), 64'h0);
    check("rst_tx", txA, 64'h0);
    check("rst_data", 64'(dataA), 64'h0);

    pulse(64'h1111_2222_3333_4444);
    check("p1_start", 64'(startA), 64'h1);
    check("p1_data", 64'(dataA), 64'h2222_1111);
    check("p1_chan", 64'(chA), 64'h0);
    tick();
    check("p1_start_off", 64'(startA), 64'h0);
    check("p1_busy", 64'(busyA), 64'h1);
    done(R1);
    check("r1_idle", 64'(busyA), 64'h0);

    pulse(64'h5555_6666_0000_0000);
    check("p2_txA", txA, R1);
    check("p2_txB", txB, 64'h0);
    check("p2_chan", 64'(chA), 64'h1);
    check("p2_data", 64'(dataA), 64'h6666_5555);
    tick();
    done(R2);
    pulse(64'h7777_8888_9999_AAAA);
    check("p3_txA", txA, R2);
    check("p3_chan", 64'(chA), 64'h0);
    tick();

    pulse(64'hBBBB_CCCC_DDDD_EEEE);
    check("ovr_flag", 64'(ovrA), 64'h1);
    check("ovr_nostart", 64'(startA), 64'h0);
    check("ovr_txA", txA, 64'h0);
    check("lat4_txB", txB, R1);
    tick();
    done(R3);
    check("stale_idle", 64'(busyA), 64'h0);
    pulse(64'h1234_5678_0000_0000);
    check("stale_txA", txA, 64'h0);
    check("p5_start", 64'(startA), 64'h1);
    check("p5_txB", txB, R2);
    check("p5_chan", 64'(chA), 64'h1);
    tick();

    rxValidIn = 1'b1; rxDataIn = 64'h0F0F_F0F0_0000_0000;
    firDoneIn = 1'b1; firResultIn = R4;
    tick();
    rxValidIn = 1'b0; firDoneIn = 1'b0;
    check("fwd_txA", txA, R4);
    check("fwd_txB", txB, 64'h0);
    check("fwd_idle", 64'(busyA), 64'h0);

    pulse(64'hAAAA_5555_0000_0000);
    check("p7_chan", 64'(chA), 64'h0);
    tick();
    abortIn = 1'b1;
    tick();
    abortIn = 1'b0;
    done(R5);
    pulse(64'h4321_8765_0000_0000);
    check("abort_chan", 64'(chA), 64'h0);
    check("p8_txA", txA, R5);
    check("p8_txB", txB, R4);
    tick();

    resetIn = 1'b1;
    #2;
    check("arst_txA", txA, 64'h0);
    check("arst_txB", txB, 64'h0);
    check("arst_busy", 64'(busyB), 64'h0);
    check("arst_ovr", 64'(ovrA), 64'h0);
    check("arst_data", 64'(dataA), 64'h0);
    tick();
    resetIn = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rxValidIn   = ($urandom_range(0, 3) == 0);
      rxDataIn    = {$urandom(), $urandom()};
      abortIn     = ($urandom_range(0, 19) == 0);
      firResultIn = {$urandom(), $urandom()};
      firDoneIn   = 1'b0;
      if (startA) cd = $urandom_range(1, 5);
      else if (cd > 0) begin
        cd--;
        if (cd == 0) firDoneIn = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) firDoneIn = 1'b1;
      resetIn = (i == 1500 || i == 1501);
      tick();
    end
    rxValidIn = 1'b0; firDoneIn = 1'b0; abortIn = 1'b0; resetIn = 1'b0;
    tick();
    compareEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMis);
    $finish;
  end

endmodule
